// File: rtl/servo_array_if.sv
// Servo array control bus: keyboard levels and UART command bytes in, PWM and status out.
// Latency: none, this is wiring only.
// Backpressure: none; bt_valid is a single-cycle strobe that is always accepted.
interface servo_array_if #(
    parameter int N_CH = 4,
    parameter int PW_W = 20
);
    logic [N_CH-1:0]      key_cw;
    logic [N_CH-1:0]      key_ccw;
    logic                 bt_valid;
    logic [7:0]           bt_data;
    logic [N_CH-1:0]      servo;
    logic [N_CH*PW_W-1:0] pos;
    logic [N_CH-1:0]      moving;
    logic [N_CH-1:0]      at_limit;

    // Stimulus side: drives requests and observes status.
    modport master (
        output key_cw, key_ccw, bt_valid, bt_data,
        input  servo, pos, moving, at_limit
    );

    // Controller side.
    modport slave (
        input  key_cw, key_ccw, bt_valid, bt_data,
        output servo, pos, moving, at_limit
    );
endinterface

// File: rtl/servo_array_ctrl.sv
// N-channel servo controller: keyboard/BT command merge, saturating positions, glitch-free PWM.
// Latency: servo is registered (1 cycle); a new position reaches the PWM in the frame after its step tick.
// Backpressure: none; every bt_valid strobe is latched, and the newest byte wins.
module servo_array_ctrl #(
    parameter int N_CH           = 4,
    parameter int PW_W           = 20,
    parameter int PERIOD         = 2000000,
    parameter int PULSE_MIN      = 50000,
    parameter int PULSE_MAX      = 250000,
    parameter int PULSE_CENTER   = 150000,
    parameter int STEP           = 1000,
    parameter int STEP_FRAMES    = 1,
    parameter int TIMEOUT_FRAMES = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    servo_array_if.slave bus
);
    localparam int FC_W  = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int CMP_W = (FC_W > PW_W) ? FC_W : PW_W;
    localparam int SC_W  = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int TO_W  = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;

    localparam logic [PW_W:0]   MIN_X  = (PW_W+1)'(PULSE_MIN);
    localparam logic [PW_W:0]   MAX_X  = (PW_W+1)'(PULSE_MAX);
    localparam logic [PW_W:0]   STEP_X = (PW_W+1)'(STEP);
    localparam logic [PW_W-1:0] CENTER = PW_W'(PULSE_CENTER);

    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [SC_W-1:0] step_cnt_q, step_cnt_d;
    logic [7:0]      bt_cmd_q, bt_cmd_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [N_CH-1:0] servo_q, servo_d;
    logic [N_CH-1:0] moving_q, moving_d;
    logic [PW_W-1:0] pos_q [N_CH];
    logic [PW_W-1:0] pos_d [N_CH];
    logic [PW_W-1:0] wsh_q [N_CH];
    logic [PW_W-1:0] wsh_d [N_CH];

    logic            frame_end;
    logic            step_tick;
    logic            home;
    logic [N_CH-1:0] up, dn;
    logic [PW_W:0]   sum   [N_CH];
    logic [PW_W-1:0] inc_w [N_CH];
    logic [PW_W-1:0] dec_w [N_CH];

    // Frame and step-tick timing.
    always_comb begin
        frame_end   = (frame_cnt_q == FC_W'(PERIOD - 1));
        frame_cnt_d = frame_end ? '0 : frame_cnt_q + 1'b1;
        step_tick   = frame_end && (step_cnt_q == SC_W'(STEP_FRAMES - 1));
        step_cnt_d  = step_cnt_q;
        if (frame_end) begin
            step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
        end
        home = (bt_cmd_q == 8'hFF);
    end

    // BT command latch: a fresh byte beats home completion, which beats the link-loss timeout.
    always_comb begin
        bt_cmd_d = bt_cmd_q;
        to_cnt_d = to_cnt_q;
        if (TIMEOUT_FRAMES > 0 && frame_end && bt_cmd_q != 8'h00) begin
            if (to_cnt_q == TO_W'(TIMEOUT_FRAMES - 1)) begin
                bt_cmd_d = 8'h00;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
        if (step_tick && home) begin
            bt_cmd_d = 8'h00;
            to_cnt_d = '0;
        end
        if (bus.bt_valid) begin
            bt_cmd_d = bus.bt_data;
            to_cnt_d = '0;
        end
    end

    // Per-channel requests and saturating candidates, computed one bit wider so nothing wraps.
    always_comb begin
        up = '0;
        dn = '0;
        for (int k = 0; k < N_CH; k++) begin
            up[k]    = bus.key_cw[k]  | (bt_cmd_q == 8'(2*k + 1));
            dn[k]    = bus.key_ccw[k] | (bt_cmd_q == 8'(2*k + 2));
            sum[k]   = {1'b0, pos_q[k]} + STEP_X;
            inc_w[k] = (sum[k] > MAX_X) ? MAX_X[PW_W-1:0] : sum[k][PW_W-1:0];
            dec_w[k] = ({1'b0, pos_q[k]} < (MIN_X + STEP_X)) ? MIN_X[PW_W-1:0]
                                                             : pos_q[k] - STEP_X[PW_W-1:0];
        end
    end

    // Position update at the step tick. The shadow width takes the post-tick value so the
    // new position is visible in the very next frame; PWM compares against the shadow only.
    always_comb begin
        moving_d = moving_q;
        servo_d  = '0;
        for (int k = 0; k < N_CH; k++) begin
            pos_d[k] = pos_q[k];
            if (step_tick) begin
                if (home) begin
                    pos_d[k]    = CENTER;
                    moving_d[k] = 1'b0;
                end else begin
                    moving_d[k] = up[k] ^ dn[k];
                    if (up[k] && !dn[k]) begin
                        pos_d[k] = inc_w[k];
                    end else if (dn[k] && !up[k]) begin
                        pos_d[k] = dec_w[k];
                    end
                end
            end
            wsh_d[k]   = frame_end ? pos_d[k] : wsh_q[k];
            servo_d[k] = CMP_W'(frame_cnt_q) < CMP_W'(wsh_q[k]);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            step_cnt_q  <= '0;
            bt_cmd_q    <= 8'h00;
            to_cnt_q    <= '0;
            servo_q     <= '0;
            moving_q    <= '0;
            for (int k = 0; k < N_CH; k++) begin
                pos_q[k] <= CENTER;
                wsh_q[k] <= CENTER;
            end
        end else begin
            frame_cnt_q <= frame_cnt_d;
            step_cnt_q  <= step_cnt_d;
            bt_cmd_q    <= bt_cmd_d;
            to_cnt_q    <= to_cnt_d;
            servo_q     <= servo_d;
            moving_q    <= moving_d;
            for (int k = 0; k < N_CH; k++) begin
                pos_q[k] <= pos_d[k];
                wsh_q[k] <= wsh_d[k];
            end
        end
    end

    // Status outputs; at_limit follows the position register directly.
    always_comb begin
        bus.servo    = servo_q;
        bus.moving   = moving_q;
        bus.pos      = '0;
        bus.at_limit = '0;
        for (int k = 0; k < N_CH; k++) begin
            bus.pos[k*PW_W +: PW_W] = pos_q[k];
            bus.at_limit[k] = (pos_q[k] == MIN_X[PW_W-1:0]) || (pos_q[k] == MAX_X[PW_W-1:0]);
        end
    end
endmodule
